// File: rtl/axi_pkg.sv
// Shared types and constants for the AXI3 write-channel subordinate.
// Holds the burst/state encodings and the burst legality rule used at AW time.
package axi_pkg;

    localparam int unsigned AddrW = 32;
    localparam int unsigned DataW = 32;
    localparam int unsigned StrbW = 4;
    localparam int unsigned LenW  = 4;
    localparam int unsigned SizeW = 3;

    typedef enum logic [1:0] {
        BurstFixed = 2'b00,
        BurstIncr  = 2'b01,
        BurstWrap  = 2'b10,
        BurstRsvd  = 2'b11
    } burst_e;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StResp
    } state_e;

    // An illegal burst is still fully accepted, but never touches memory.
    function automatic logic burst_illegal(input logic [AddrW-1:0] addr,
                                           input logic [LenW-1:0]  len,
                                           input logic [SizeW-1:0] size,
                                           input burst_e           burst);
        logic [AddrW-1:0] mask;
        logic             wrap_len_ok;
        logic             wrap_bad;
        mask        = (AddrW'(1) << size) - AddrW'(1);
        wrap_len_ok = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
        wrap_bad    = (burst == BurstWrap) && (!wrap_len_ok || ((addr & mask) != '0));
        return (size > 3'd2) || (burst == BurstRsvd) || wrap_bad;
    endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational beat-to-beat address stepping for FIXED, INCR and WRAP bursts.
// All arithmetic is 32-bit; carry out of the top bit is dropped.
module axi_burst_addr_gen
    import axi_pkg::*;
(
    input  logic [AddrW-1:0] addr_i,
    input  logic [SizeW-1:0] size_i,
    input  logic [LenW-1:0]  len_i,
    input  burst_e           burst_i,
    output logic [AddrW-1:0] next_addr_o,
    output logic [AddrW-1:0] wrap_low_o
);

    logic [AddrW-1:0] bytes;
    logic [AddrW-1:0] total;
    logic [AddrW-1:0] low;
    logic [AddrW-1:0] inc;

    always_comb begin
        bytes = AddrW'(1) << size_i;
        total = bytes * (AddrW'(len_i) + AddrW'(1));
        low   = addr_i & ~(total - AddrW'(1));
        inc   = addr_i + bytes;

        unique case (burst_i)
            BurstFixed: next_addr_o = addr_i;
            BurstIncr:  next_addr_o = (addr_i & ~(bytes - AddrW'(1))) + bytes;
            BurstWrap:  next_addr_o = (inc == (low + total)) ? low : inc;
            default:    next_addr_o = addr_i;
        endcase

        wrap_low_o = low;
    end

endmodule

// File: rtl/axi_write_slave.sv
// AXI3 write subordinate: one burst at a time into a word-addressed 32-bit memory,
// with a combinational debug read port that reflects committed memory contents.
module axi_write_slave
    import axi_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 256,
    parameter int unsigned ID_W      = 4
) (
    input  logic             ACLK,
    input  logic             ARESET,
    input  logic [ID_W-1:0]  AWID,
    input  logic [31:0]      AWADDR,
    input  logic [3:0]       AWLEN,
    input  logic [2:0]       AWSIZE,
    input  logic [1:0]       AWBURST,
    input  logic             AWVALID,
    output logic             AWREADY,
    input  logic [ID_W-1:0]  WID,
    input  logic [31:0]      WDATA,
    input  logic [3:0]       WSTRB,
    input  logic             WLAST,
    input  logic             WVALID,
    output logic             WREADY,
    output logic [ID_W-1:0]  BID,
    output logic [1:0]       BRESP,
    output logic             BVALID,
    input  logic             BREADY,
    input  logic [31:0]      dbg_addr,
    output logic [31:0]      dbg_rdata
);

    localparam int unsigned IdxW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    state_e           st_q, st_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [AddrW-1:0] addr_q, addr_d;
    logic [LenW-1:0]  len_q, len_d;
    logic [SizeW-1:0] size_q, size_d;
    burst_e           burst_q, burst_d;
    logic [LenW-1:0]  cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             bad_q, bad_d;
    logic [ID_W-1:0]  bid_q, bid_d;
    logic [1:0]       bresp_q, bresp_d;

    logic [DataW-1:0] mem_q [MEM_WORDS];
    logic             mem_we;
    logic [IdxW-1:0]  mem_idx;

    logic [AddrW-1:0] next_addr;
    logic [AddrW-1:0] unused_wrap_low;
    logic             aw_hs, w_hs, b_hs;
    logic             beat_last, beat_oor, wid_bad, beat_err, aw_illegal;
    logic             dbg_in_range;
    logic             unused_dbg;

    axi_burst_addr_gen u_addr_gen (
        .addr_i      (addr_q),
        .size_i      (size_q),
        .len_i       (len_q),
        .burst_i     (burst_q),
        .next_addr_o (next_addr),
        .wrap_low_o  (unused_wrap_low)
    );

    // Handshake readies are masked during reset so nothing is accepted mid-reset.
    assign AWREADY = (st_q == StIdle) && !ARESET;
    assign WREADY  = (st_q == StData) && !ARESET;
    assign BVALID  = (st_q == StResp) && !ARESET;
    assign BID     = bid_q;
    assign BRESP   = bresp_q;

    assign aw_hs = AWVALID && AWREADY;
    assign w_hs  = WVALID && WREADY;
    assign b_hs  = BVALID && BREADY;

    assign aw_illegal = burst_illegal(AWADDR, AWLEN, AWSIZE, burst_e'(AWBURST));
    assign beat_last  = (cnt_q == len_q);
    assign beat_oor   = {2'b00, addr_q[AddrW-1:2]} >= MEM_WORDS;
    assign wid_bad    = (WID != id_q);
    assign beat_err   = wid_bad || beat_oor || (WLAST != beat_last);
    assign mem_idx    = addr_q[IdxW+1:2];

    always_comb begin
        st_d    = st_q;
        id_d    = id_q;
        addr_d  = addr_q;
        len_d   = len_q;
        size_d  = size_q;
        burst_d = burst_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        bad_d   = bad_q;
        bid_d   = bid_q;
        bresp_d = bresp_q;
        mem_we  = 1'b0;

        unique case (st_q)
            StIdle: begin
                if (aw_hs) begin
                    id_d    = AWID;
                    addr_d  = AWADDR;
                    len_d   = AWLEN;
                    size_d  = AWSIZE;
                    burst_d = burst_e'(AWBURST);
                    cnt_d   = '0;
                    err_d   = aw_illegal;
                    bad_d   = aw_illegal;
                    st_d    = StData;
                end
            end
            StData: begin
                if (w_hs) begin
                    mem_we = !bad_q && !beat_oor && !wid_bad;
                    err_d  = err_q || beat_err;
                    addr_d = next_addr;
                    cnt_d  = cnt_q + LenW'(1);
                    if (beat_last) begin
                        st_d    = StResp;
                        bid_d   = id_q;
                        bresp_d = (err_q || beat_err) ? RespSlverr : RespOkay;
                    end
                end
            end
            StResp: begin
                if (b_hs) begin
                    st_d = StIdle;
                end
            end
            default: st_d = StIdle;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            st_q    <= StIdle;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= BurstFixed;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            bad_q   <= 1'b0;
            bid_q   <= '0;
            bresp_q <= RespOkay;
        end else begin
            st_q    <= st_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            size_q  <= size_d;
            burst_q <= burst_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            bad_q   <= bad_d;
            bid_q   <= bid_d;
            bresp_q <= bresp_d;
        end
    end

    // Memory has no reset; strobes are applied exactly as presented.
    always_ff @(posedge ACLK) begin
        if (mem_we) begin
            for (int i = 0; i < StrbW; i++) begin
                if (WSTRB[i]) begin
                    mem_q[mem_idx][8*i +: 8] <= WDATA[8*i +: 8];
                end
            end
        end
    end

    assign dbg_in_range = {2'b00, dbg_addr[31:2]} < MEM_WORDS;
    assign dbg_rdata    = dbg_in_range ? mem_q[dbg_addr[IdxW+1:2]] : '0;
    assign unused_dbg   = ^{dbg_addr[1:0], unused_wrap_low};

endmodule
